// File: rtl/prll_bs_rr_rbtr.sv
// Round-robin arbiter moving one word at a time from per-driver outgoing FIFOs to
// incoming FIFOs. Define PRLL_BS_BCST_EN to deliver the broadcast ID to all but the source.
module prll_bs_rr_rbtr #(
  parameter int         bits      = 32,
  parameter int         drvrs     = 4,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [drvrs-1:0]       pndng,
  input  logic [drvrs*bits-1:0]  D_pop,
  output logic [drvrs-1:0]       pop,
  input  logic [drvrs-1:0]       full,
  output logic [drvrs-1:0]       push,
  output logic [drvrs*bits-1:0]  D_push,
  output logic                   busy,
  output logic [15:0]            drop_cnt
);

  localparam int GW = $clog2(drvrs);

`ifdef PRLL_BS_BCST_EN
  localparam bit BcstEn = 1'b1;
`else
  localparam bit BcstEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, POP, SEND} state_t;

  state_t          r_state, w_state_nxt;
  logic [GW-1:0]   r_grant, r_last_grant, w_rr_pick;
  logic            w_rr_hit;
  logic [bits-1:0] r_data_q;
  logic [GW-1:0]   r_src_q;
  logic [15:0]     r_drop_cnt;
  logic [7:0]      w_dest;
  logic            w_dest_ok, w_is_bcst, w_drop;
  logic [drvrs-1:0] w_dest_oh, w_bcst_mask, w_grant_oh;

  // Round-robin search starting one past the last grant.
  always_comb begin : rr_search
    int v_idx;
    v_idx     = 0;
    w_rr_pick = r_last_grant;
    w_rr_hit  = 1'b0;
    for (int k = 1; k <= drvrs; k++) begin
      v_idx = int'(r_last_grant) + k;
      if (v_idx >= drvrs) v_idx = v_idx - drvrs;
      if (!w_rr_hit && pndng[GW'(v_idx)]) begin
        w_rr_hit  = 1'b1;
        w_rr_pick = GW'(v_idx);
      end
    end
  end

  assign w_dest    = r_data_q[bits-1 -: 8];
  assign w_dest_ok = int'(w_dest) < drvrs;
  assign w_is_bcst = (w_dest == broadcast);

  always_comb begin
    for (int i = 0; i < drvrs; i++) begin
      w_dest_oh[i]   = (int'(w_dest) == i);
      w_bcst_mask[i] = (int'(r_src_q) != i);
      w_grant_oh[i]  = (int'(r_grant) == i);
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    pop         = '0;
    push        = '0;
    w_drop      = 1'b0;
    case (r_state)
      IDLE: if (w_rr_hit) w_state_nxt = POP;
      POP: begin
        pop         = w_grant_oh & pndng;
        w_state_nxt = pndng[r_grant] ? SEND : IDLE;
      end
      SEND: begin
        if (w_dest_ok) begin
          if (!(|(full & w_dest_oh))) begin
            push        = w_dest_oh;
            w_state_nxt = IDLE;
          end
        end else if (BcstEn && w_is_bcst) begin
          if (!(|(full & w_bcst_mask))) begin
            push        = w_bcst_mask;
            w_state_nxt = IDLE;
          end
        end else begin
          w_drop      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // NOTE: strobes are combinational, so a reset cycle must mask them to kill the in-flight word.
    if (reset) begin
      pop  = '0;
      push = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= GW'(drvrs - 1);
      r_data_q     <= '0;
      r_src_q      <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_rr_hit) begin
        r_grant      <= w_rr_pick;
        r_last_grant <= w_rr_pick;
      end
      if (r_state == POP && pndng[r_grant]) begin
        r_data_q <= D_pop[r_grant*bits +: bits];
        r_src_q  <= r_grant;
      end
      if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign D_push   = {drvrs{r_data_q}};
  assign busy     = (r_state != IDLE);
  assign drop_cnt = r_drop_cnt;

endmodule
